// File: rtl/program_loader.sv
// Framed byte-stream loader: parses SYNC/address/length header, writes payload to program memory,
// verifies an 8-bit additive checksum and releases the CPU from reset on success.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | hunting for SYNC_BYTE, other bytes discarded
// S_ADDR_HI | expecting start address high byte
// S_ADDR_LO | expecting start address low byte, loads write pointer
// S_LEN_HI  | expecting payload length high byte
// S_LEN_LO  | expecting length low byte, validates length
// S_DATA    | writing payload bytes, one every two clocks
// S_CHECK   | expecting checksum byte
module program_loader #(
    parameter int          ADDRESS_WIDTH  = 12,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 12000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [7:0]               mem_data_out,
    output logic                     mem_write_enable,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic                     load_error
);

    localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]     TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]       MAX_LEN  = 32'd1 << ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               addr_hi_q, addr_hi_d;
    logic [7:0]               len_hi_q, len_hi_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]              remaining_q, remaining_d;
    logic [7:0]               sum_q, sum_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     rx_ready_q, rx_ready_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [7:0]               mem_data_q, mem_data_d;
    logic                     we_q, we_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     load_done_q, load_done_d;
    logic                     load_error_q, load_error_d;

    logic        accept;
    logic        timed_out;
    logic [15:0] len_full;
    logic [7:0]  chk_sum;

    assign accept    = rx_valid && rx_ready_q;
    assign timed_out = (state_q != S_IDLE) && (timer_q == '0);
    assign len_full  = {len_hi_q, rx_data};
    assign chk_sum   = sum_q + rx_data;

    always_comb begin
        state_d       = state_q;
        addr_hi_d     = addr_hi_q;
        len_hi_d      = len_hi_q;
        ptr_d         = ptr_q;
        remaining_d   = remaining_q;
        sum_d         = sum_q;
        timer_d       = timer_q;
        rx_ready_d    = 1'b1;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        we_d          = 1'b0;
        cpu_hold_d    = cpu_hold_q;
        load_done_d   = load_done_q;
        load_error_d  = load_error_q;

        if (state_q != S_IDLE && timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end

        // A timeout wins over a byte arriving in the same cycle; that byte is lost.
        if (timed_out) begin
            state_d      = S_IDLE;
            load_error_d = 1'b1;
        end else if (accept) begin
            timer_d = TMO_LOAD;
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d      = S_ADDR_HI;
                        load_done_d  = 1'b0;
                        load_error_d = 1'b0;
                        cpu_hold_d   = 1'b1;
                    end
                end
                S_ADDR_HI: begin
                    addr_hi_d = rx_data;
                    state_d   = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    ptr_d   = ADDRESS_WIDTH'({addr_hi_q, rx_data});
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (len_full == 16'd0 || {16'd0, len_full} > MAX_LEN) begin
                        state_d      = S_IDLE;
                        load_error_d = 1'b1;
                    end else begin
                        remaining_d = len_full;
                        sum_d       = 8'd0;
                        state_d     = S_DATA;
                    end
                end
                S_DATA: begin
                    we_d          = 1'b1;
                    rx_ready_d    = 1'b0;
                    mem_address_d = ptr_q;
                    mem_data_d    = rx_data;
                    ptr_d         = ptr_q + ADDRESS_WIDTH'(1);
                    sum_d         = chk_sum;
                    remaining_d   = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (chk_sum == 8'd0) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_hi_q     <= '0;
            len_hi_q      <= '0;
            ptr_q         <= '0;
            remaining_q   <= '0;
            sum_q         <= '0;
            timer_q       <= '0;
            rx_ready_q    <= 1'b1;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            we_q          <= 1'b0;
            cpu_hold_q    <= 1'b1;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_hi_q     <= addr_hi_d;
            len_hi_q      <= len_hi_d;
            ptr_q         <= ptr_d;
            remaining_q   <= remaining_d;
            sum_q         <= sum_d;
            timer_q       <= timer_d;
            rx_ready_q    <= rx_ready_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            we_q          <= we_d;
            cpu_hold_q    <= cpu_hold_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
        end
    end

    assign rx_ready         = rx_ready_q;
    assign mem_address      = mem_address_q;
    assign mem_data_out     = mem_data_q;
    assign mem_write_enable = we_q;
    assign cpu_hold         = cpu_hold_q;
    assign load_done        = load_done_q;
    assign load_error       = load_error_q;

endmodule
